reg_rom: RTL and testbench

//  4-bit register file of the microcoded processor datapath: registers A, B, C.

---
 rtl/reg_rom_pkg.sv | 54 +++++
 rtl/reg_rom_decode.sv | 44 ++++
 rtl/reg_rom.sv | 99 +++++++++
 tb/tb_reg_rom.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/reg_rom_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_rom_pkg
// Purpose  : Shared widths, micro-op encodings and decode bundle for reg_rom.
// Revision : 1.0 - initial release
// ============================================================================
package reg_rom_pkg;

    localparam int DEF_DW = 4;
    localparam int DEF_IW = 4;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_LDB  = 4'h2;
    localparam logic [3:0] OP_LDC  = 4'h3;
    localparam logic [3:0] OP_RDA  = 4'h4;
    localparam logic [3:0] OP_RDB  = 4'h5;
    localparam logic [3:0] OP_OUTA = 4'h6;
    localparam logic [3:0] OP_OUTB = 4'h7;
    localparam logic [3:0] OP_OUTC = 4'h8;
    localparam logic [3:0] OP_MAB  = 4'h9;
    localparam logic [3:0] OP_MBA  = 4'hA;
    localparam logic [3:0] OP_MCA  = 4'hB;
    localparam logic [3:0] OP_OUTI = 4'hC;
    localparam logic [3:0] OP_RSVD = 4'hD;
    localparam logic [3:0] OP_RSVE = 4'hE;
    localparam logic [3:0] OP_CLR  = 4'hF;

    // SRC_REG means "the other register" for the move ops: B for A, A for B and C.
    typedef enum logic [1:0] {
        SRC_IMM  = 2'd0,
        SRC_BUS  = 2'd1,
        SRC_REG  = 2'd2,
        SRC_ZERO = 2'd3
    } src_sel_e;

    typedef enum logic [1:0] {
        DRV_A   = 2'd0,
        DRV_B   = 2'd1,
        DRV_C   = 2'd2,
        DRV_IMM = 2'd3
    } drv_sel_e;

    typedef struct packed {
        logic     we_a;
        logic     we_b;
        logic     we_c;
        src_sel_e src;
        logic     drv_en;
        drv_sel_e drv_sel;
    } decode_t;

endpackage : reg_rom_pkg
`default_nettype wire

// File: rtl/reg_rom_decode.sv
`default_nettype none
// ============================================================================
// Module   : reg_rom_decode
// Purpose  : Micro-op decoder: write enables, load source and bus drive select.
// Revision : 1.0 - initial release
// ============================================================================
module reg_rom_decode
    import reg_rom_pkg::*;
#(
    parameter int IW = DEF_IW
) (
    input  logic [IW-1:0] instr,
    output decode_t       dec
);

    always_comb begin
        dec         = '0;
        dec.src     = SRC_IMM;
        dec.drv_sel = DRV_A;
        case (instr)
            OP_LDA:  dec.we_a = 1'b1;
            OP_LDB:  dec.we_b = 1'b1;
            OP_LDC:  dec.we_c = 1'b1;
            OP_RDA:  begin dec.we_a = 1'b1; dec.src = SRC_BUS; end
            OP_RDB:  begin dec.we_b = 1'b1; dec.src = SRC_BUS; end
            OP_OUTA: begin dec.drv_en = 1'b1; dec.drv_sel = DRV_A;   end
            OP_OUTB: begin dec.drv_en = 1'b1; dec.drv_sel = DRV_B;   end
            OP_OUTC: begin dec.drv_en = 1'b1; dec.drv_sel = DRV_C;   end
            OP_OUTI: begin dec.drv_en = 1'b1; dec.drv_sel = DRV_IMM; end
            OP_MAB:  begin dec.we_a = 1'b1; dec.src = SRC_REG; end
            OP_MBA:  begin dec.we_b = 1'b1; dec.src = SRC_REG; end
            OP_MCA:  begin dec.we_c = 1'b1; dec.src = SRC_REG; end
            OP_CLR:  begin
                dec.we_a = 1'b1;
                dec.we_b = 1'b1;
                dec.we_c = 1'b1;
                dec.src  = SRC_ZERO;
            end
            default: ;
        endcase
    end

endmodule : reg_rom_decode
`default_nettype wire

// File: rtl/reg_rom.sv
`default_nettype none
// ============================================================================
// Module   : reg_rom
// Purpose  : Three-register (A/B/C) file driving/loading a shared tri-state bus.
//            Define REG_ROM_DEBUG_EN to expose dbg_regs = {A,B,C}.
// Revision : 1.0 - initial release
// ============================================================================
module reg_rom
    import reg_rom_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int IW = DEF_IW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] imm,
    input  logic [IW-1:0] instr,
    inout  wire  [DW-1:0] bus
`ifdef REG_ROM_DEBUG_EN
    ,
    output logic [3*DW-1:0] dbg_regs
`endif
);

    decode_t       dec;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] c_q, c_d;
    logic [DW-1:0] drv_val;
    logic          drv_on;

    reg_rom_decode #(.IW(IW)) u_decode (
        .instr (instr),
        .dec   (dec)
    );

    // Move ops read pre-edge register values, so every source is a _q.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        if (dec.we_a) begin
            case (dec.src)
                SRC_IMM: a_d = imm;
                SRC_BUS: a_d = bus;
                SRC_REG: a_d = b_q;
                default: a_d = '0;
            endcase
        end
        if (dec.we_b) begin
            case (dec.src)
                SRC_IMM: b_d = imm;
                SRC_BUS: b_d = bus;
                SRC_REG: b_d = a_q;
                default: b_d = '0;
            endcase
        end
        if (dec.we_c) begin
            case (dec.src)
                SRC_IMM: c_d = imm;
                SRC_BUS: c_d = bus;
                SRC_REG: c_d = a_q;
                default: c_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
        end
    end

    always_comb begin
        drv_val = '0;
        case (dec.drv_sel)
            DRV_A:   drv_val = a_q;
            DRV_B:   drv_val = b_q;
            DRV_C:   drv_val = c_q;
            default: drv_val = imm;
        endcase
    end

    // The bus is released whenever reset is held, whatever the micro-op.
    assign drv_on = dec.drv_en & rst_n;
    assign bus    = drv_on ? drv_val : {DW{1'bz}};

`ifdef REG_ROM_DEBUG_EN
    assign dbg_regs = {a_q, b_q, c_q};
`endif

endmodule : reg_rom
`default_nettype wire

// File: tb/tb_reg_rom.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_rom
// Purpose  : Self-checking bench for reg_rom; a released bus reads 4'hF (pullups).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_rom;

    localparam logic [3:0] FLOAT = 4'hF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] imm;
    logic [3:0] instr;
    logic       drv_en;
    logic [3:0] drv_val;
    wire  [3:0] bus;
`ifdef REG_ROM_DEBUG_EN
    logic [11:0] dbg_regs;
`endif

    int checks = 0;
    int errors = 0;

    // Reference register file: index 0=A, 1=B, 2=C.
    logic [3:0] m [3];

    assign bus = drv_en ? drv_val : 4'bz;
    pullup (bus[0]);
    pullup (bus[1]);
    pullup (bus[2]);
    pullup (bus[3]);

    always #5 clk = ~clk;

    reg_rom dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .imm      (imm),
        .instr    (instr),
        .bus      (bus)
`ifdef REG_ROM_DEBUG_EN
        ,
        .dbg_regs (dbg_regs)
`endif
    );

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_bus(input int op, input logic [3:0] iv,
                                           input logic den, input logic [3:0] dv);
        if (den)     return dv;
        if (op == 6) return m[0];
        if (op == 7) return m[1];
        if (op == 8) return m[2];
        if (op == 12) return iv;
        return FLOAT;
    endfunction

    task automatic model_update(input int op, input logic [3:0] iv, input logic [3:0] dv);
        logic [3:0] a, b;
        a = m[0];
        b = m[1];
        case (op)
            1:  m[0] = iv;
            2:  m[1] = iv;
            3:  m[2] = iv;
            4:  m[0] = dv;
            5:  m[1] = dv;
            9:  m[0] = b;
            10: m[1] = a;
            11: m[2] = a;
            15: begin m[0] = 0; m[1] = 0; m[2] = 0; end
            default: ;
        endcase
    endtask

    // One micro-op: apply at negedge, check bus (and regs) mid-cycle, then commit.
    task automatic step(input int op, input logic [3:0] iv, input logic den,
                        input logic [3:0] dv, input string tag);
        @(negedge clk);
        instr   = op[3:0];
        imm     = iv;
        drv_en  = den;
        drv_val = dv;
        #1;
        check_eq(tag, {8'h0, bus}, {8'h0, exp_bus(op, iv, den, dv)});
`ifdef REG_ROM_DEBUG_EN
        check_eq({tag, "_dbg"}, dbg_regs, {m[0], m[1], m[2]});
`endif
        @(posedge clk);
        model_update(op, iv, dv);
    endtask

    initial begin
        rst_n   = 1'b0;
        instr   = 4'h6;
        imm     = 4'h0;
        drv_en  = 1'b0;
        drv_val = 4'h0;
        m[0] = 0; m[1] = 0; m[2] = 0;

        // Reset holds the bus released even with OUTA presented.
        #1;
        check_eq("rst_bus_z", {8'h0, bus}, {8'h0, FLOAT});
`ifdef REG_ROM_DEBUG_EN
        check_eq("rst_dbg", dbg_regs, 12'h000);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(6, 4'h0, 1'b0, 4'h0, "rel_outa");

        // Immediate loads and register drives.
        step(1, 4'hA, 1'b0, 4'h0, "lda");
        step(2, 4'h7, 1'b0, 4'h0, "ldb");
        step(3, 4'h5, 1'b0, 4'h0, "ldc");
        step(6, 4'h0, 1'b0, 4'h0, "outa_A");
        step(7, 4'h0, 1'b0, 4'h0, "outb_7");
        step(8, 4'h0, 1'b0, 4'h0, "outc_5");

        // Loads from the bus driven by the bench.
        step(4, 4'h0, 1'b1, 4'h2, "rda");
        step(5, 4'h0, 1'b1, 4'h8, "rdb");
        step(6, 4'h0, 1'b0, 4'h0, "outa_2");
        step(7, 4'h0, 1'b0, 4'h0, "outb_8");

        // Register moves.
        step(9,  4'h0, 1'b0, 4'h0, "mab");
        step(6,  4'h0, 1'b0, 4'h0, "mab_a8");
        step(10, 4'h0, 1'b0, 4'h0, "mba");
        step(7,  4'h0, 1'b0, 4'h0, "mba_b8");
        step(11, 4'h0, 1'b0, 4'h0, "mca");
        step(8,  4'h0, 1'b0, 4'h0, "mca_c8");

        // Immediate drive, reserved ops.
        step(12, 4'h3, 1'b0, 4'h0, "outi_3");
        step(13, 4'h9, 1'b0, 4'h0, "rsvd_d");
        step(14, 4'h9, 1'b0, 4'h0, "rsvd_e");
        step(6,  4'h0, 1'b0, 4'h0, "rsvd_a");
        step(7,  4'h0, 1'b0, 4'h0, "rsvd_b");
        step(8,  4'h0, 1'b0, 4'h0, "rsvd_c");

        // Clear.
        step(15, 4'h0, 1'b0, 4'h0, "clr");
        step(6,  4'h0, 1'b0, 4'h0, "clr_a");
        step(7,  4'h0, 1'b0, 4'h0, "clr_b");
        step(8,  4'h0, 1'b0, 4'h0, "clr_c");

        // Asynchronous reset pulse entirely between clock edges.
        step(1, 4'h6, 1'b0, 4'h0, "pre_lda");
        step(2, 4'h4, 1'b0, 4'h0, "pre_ldb");
        step(3, 4'h2, 1'b0, 4'h0, "pre_ldc");
        @(negedge clk);
        instr = 4'h6;
        imm   = 4'h0;
        #1;
        check_eq("pre_pulse_a", {8'h0, bus}, 12'h006);
        rst_n = 1'b0;
        m[0] = 0; m[1] = 0; m[2] = 0;
        #1;
        check_eq("pulse_bus_z", {8'h0, bus}, {8'h0, FLOAT});
`ifdef REG_ROM_DEBUG_EN
        check_eq("pulse_dbg", dbg_regs, 12'h000);
`endif
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("pulse_a0", {8'h0, bus}, 12'h000);
        step(7, 4'h0, 1'b0, 4'h0, "pulse_b0");
        step(8, 4'h0, 1'b0, 4'h0, "pulse_c0");

        // Randomized micro-op stream against the reference model.
        for (int i = 0; i < 400; i++) begin
            int         op;
            logic [3:0] iv, dv;
            op = int'($urandom_range(0, 15));
            iv = 4'($urandom);
            dv = 4'($urandom);
            step(op, iv, (op == 4 || op == 5), dv, $sformatf("rnd%0d_op%0h", i, op));
        end
        step(6, 4'h0, 1'b0, 4'h0, "end_a");
        step(7, 4'h0, 1'b0, 4'h0, "end_b");
        step(8, 4'h0, 1'b0, 4'h0, "end_c");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_rom
`default_nettype wire
